// File: rtl/io_map_pkg.sv
// -----------------------------------------------------------------------------
// io_map_pkg
// Shared I/O address map for the CPU memory-mapped load/store path. Imported
// by the address decoder and by io_read_return so both agree on the map.
//   - address constants (11-bit word addresses)
//   - region_e : where a load is served from
//   - state_e  : io_read_return FSM states
//   - decode_region() : rd_addr -> region
// -----------------------------------------------------------------------------
package io_map_pkg;

  localparam int          ADDR_W          = 11;
  localparam int          MEM_BIT         = 10;      // addr[10]=0 selects data RAM
  localparam logic [10:0] ADDR_LED        = 11'h401;
  localparam logic [10:0] ADDR_SWITCH     = 11'h402;
  localparam logic [10:0] ADDR_BUTTON     = 11'h403;
  localparam logic [10:0] ADDR_SEG        = 11'h404;
  localparam logic [10:0] ADDR_UART       = 11'h405;
  localparam logic [2:0]  ADDR_VGA_PREFIX = 3'b101;  // 0x5xx
  localparam int          SYNC_STAGES     = 2;

  typedef enum logic [2:0] {
    REG_MEM,
    REG_SWITCH,
    REG_BUTTON,
    REG_UART,
    REG_BAD
  } region_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_UART_WAIT
  } state_e;

  // Anything not readable (LED, SEG, VGA, unmapped) falls into REG_BAD.
  function automatic region_e decode_region(input logic [ADDR_W-1:0] addr);
    region_e region;
    if (!addr[MEM_BIT]) begin
      region = REG_MEM;
    end else begin
      case (addr)
        ADDR_SWITCH: region = REG_SWITCH;
        ADDR_BUTTON: region = REG_BUTTON;
        ADDR_UART:   region = REG_UART;
        default:     region = REG_BAD;
      endcase
    end
    return region;
  endfunction

endpackage

// File: rtl/io_sync.sv
// -----------------------------------------------------------------------------
// io_sync
// Multi-flop synchronizer for slow asynchronous levels (switches, buttons).
// Parameters: WIDTH (bits), DEPTH (flop stages, >= 1).
// Ports:
//   clk      in   system clock
//   rst      in   asynchronous active-high reset, clears all stages
//   data_in  in   WIDTH  raw asynchronous levels
//   data_out out  WIDTH  synchronized levels, DEPTH cycles behind
// -----------------------------------------------------------------------------
module io_sync #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out
);

  logic [DEPTH-1:0][WIDTH-1:0] stages_q;
  logic [DEPTH-1:0][WIDTH-1:0] stages_d;

  always_comb begin
    stages_d[0] = data_in;
    for (int i = 1; i < DEPTH; i++) begin
      stages_d[i] = stages_q[i-1];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples the previous stage's old value on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stages_q <= '0;
    end else begin
      stages_q <= stages_d;
    end
  end

  assign data_out = stages_q[DEPTH-1];

endmodule

// File: rtl/io_read_return.sv
// -----------------------------------------------------------------------------
// io_read_return
// Read-return responder for the CPU load path. Accepts a one-cycle load
// request, collects the word from data RAM, switches, buttons or the UART
// receiver, and returns one registered word. Stalls the CPU while busy and
// flags reads of write-only/unmapped locations (and UART timeouts).
//
// Optional feature macro: IO_READ_TIMEOUT_EN
//   defined   : UART_WAIT has a wait counter; after TIMEOUT cycles the read
//               returns 0 with rd_err=1.
//   undefined : UART_WAIT waits indefinitely; no counter exists.
//
// Parameters: DATA_W (32), SW_W (16), BTN_W (5), TIMEOUT (1023, >= 1)
// Ports:
//   clk           in   system clock
//   rst           in   asynchronous active-high reset
//   rd_req        in   load request pulse
//   rd_addr       in   11-bit word address
//   mem_rdata     in   RAM data, valid one cycle after the address
//   switch_in     in   raw switch levels
//   button_in     in   raw button levels
//   uart_rx_data  in   received byte
//   uart_rx_valid in   received byte available (level)
//   uart_rx_ack   out  pops the UART byte (pulse, same cycle as rd_valid)
//   rd_valid      out  rd_data valid pulse
//   rd_data       out  returned word, holds between responses
//   rd_err        out  error qualifier of rd_valid
//   stall         out  CPU hold (combinational)
// -----------------------------------------------------------------------------
module io_read_return
  import io_map_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int SW_W    = 16,
  parameter int BTN_W   = 5,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_req,
  input  logic [10:0]       rd_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [SW_W-1:0]   switch_in,
  input  logic [BTN_W-1:0]  button_in,
  input  logic [7:0]        uart_rx_data,
  input  logic              uart_rx_valid,
  output logic              uart_rx_ack,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_err,
  output logic              stall
);

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("io_read_return: TIMEOUT must be at least 1");
  end

  state_e            state_q,    state_d;
  region_e           region_q,   region_d;
  logic              rd_valid_q, rd_valid_d;
  logic              rd_err_q,   rd_err_d;
  logic              ack_q,      ack_d;
  logic [DATA_W-1:0] rd_data_q,  rd_data_d;
  logic [SW_W-1:0]   sw_sync;
  logic [BTN_W-1:0]  btn_sync;
  region_e           req_region;

`ifdef IO_READ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  io_sync #(.WIDTH(SW_W), .DEPTH(SYNC_STAGES)) u_sync_sw (
    .clk      (clk),
    .rst      (rst),
    .data_in  (switch_in),
    .data_out (sw_sync)
  );

  io_sync #(.WIDTH(BTN_W), .DEPTH(SYNC_STAGES)) u_sync_btn (
    .clk      (clk),
    .rst      (rst),
    .data_in  (button_in),
    .data_out (btn_sync)
  );

  assign req_region = decode_region(rd_addr);

  // NOTE: every always_comb output gets a default first so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    region_d   = region_q;
    rd_valid_d = 1'b0;
    rd_err_d   = 1'b0;
    ack_d      = 1'b0;
    rd_data_d  = rd_data_q;
`ifdef IO_READ_TIMEOUT_EN
    cnt_d      = cnt_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (rd_req) begin
          region_d = req_region;
          if (req_region == REG_UART) begin
            state_d = ST_UART_WAIT;
`ifdef IO_READ_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end else begin
            state_d = ST_FETCH;
          end
        end
      end

      // RAM data is valid this cycle (one after the address); the other
      // sources are simply sampled here too.
      ST_FETCH: begin
        rd_valid_d = 1'b1;
        state_d    = ST_IDLE;
        case (region_q)
          REG_MEM:    rd_data_d = mem_rdata;
          REG_SWITCH: rd_data_d = DATA_W'(sw_sync);
          REG_BUTTON: rd_data_d = DATA_W'(btn_sync);
          default: begin
            rd_data_d = '0;
            rd_err_d  = 1'b1;
          end
        endcase
      end

      // Incoming data is checked before the timeout so a byte arriving in the
      // expiry cycle is still returned without error.
      ST_UART_WAIT: begin
        if (uart_rx_valid) begin
          rd_data_d  = DATA_W'(uart_rx_data);
          rd_valid_d = 1'b1;
          ack_d      = 1'b1;
          state_d    = ST_IDLE;
        end
`ifdef IO_READ_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT)) begin
          rd_data_d  = '0;
          rd_valid_d = 1'b1;
          rd_err_d   = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          // Saturates at TIMEOUT: the branch above fires before any wrap.
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      region_q   <= REG_MEM;
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
      ack_q      <= 1'b0;
      rd_data_q  <= '0;
`ifdef IO_READ_TIMEOUT_EN
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      region_q   <= region_d;
      rd_valid_q <= rd_valid_d;
      rd_err_q   <= rd_err_d;
      ack_q      <= ack_d;
      rd_data_q  <= rd_data_d;
`ifdef IO_READ_TIMEOUT_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  assign rd_valid    = rd_valid_q;
  assign rd_err      = rd_err_q;
  assign uart_rx_ack = ack_q;
  assign rd_data     = rd_data_q;
  // Drops in the rd_valid cycle because the FSM is back in IDLE by then.
  assign stall       = (state_q == ST_IDLE && rd_req) || (state_q != ST_IDLE);

endmodule

// File: tb/tb_io_read_return.sv
// -----------------------------------------------------------------------------
// tb_io_read_return
// Scoreboard bench for io_read_return. Stimulus pushes the expected response
// (data, err, ack, cycle) into a queue; a negedge monitor pops and compares on
// every rd_valid. Timeout cases run only when IO_READ_TIMEOUT_EN is defined.
// -----------------------------------------------------------------------------
module tb_io_read_return;

  localparam int DATA_W = 32;
  localparam int SW_W   = 16;
  localparam int BTN_W  = 5;
  localparam int T      = 8;
  localparam logic [31:0] JUNK = 32'h1234_5678;

  logic              clk = 1'b0;
  logic              rst;
  logic              rd_req;
  logic [10:0]       rd_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic [SW_W-1:0]   switch_in;
  logic [BTN_W-1:0]  button_in;
  logic [7:0]        uart_rx_data;
  logic              uart_rx_valid;
  logic              uart_rx_ack;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              rd_err;
  logic              stall;

  typedef struct {
    logic [31:0] data;
    logic        err;
    logic        ack;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  io_read_return #(
    .DATA_W (DATA_W),
    .SW_W   (SW_W),
    .BTN_W  (BTN_W),
    .TIMEOUT(T)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rd_req       (rd_req),
    .rd_addr      (rd_addr),
    .mem_rdata    (mem_rdata),
    .switch_in    (switch_in),
    .button_in    (button_in),
    .uart_rx_data (uart_rx_data),
    .uart_rx_valid(uart_rx_valid),
    .uart_rx_ack  (uart_rx_ack),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data),
    .rd_err       (rd_err),
    .stall        (stall)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare every response against the scoreboard head.
  always @(negedge clk) begin
    if (!rst) begin
      if (rd_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_rd_valid", 64'(rd_valid), 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("rd_data",     64'(rd_data),     64'(e.data));
          check("rd_err",      64'(rd_err),      64'(e.err));
          check("uart_rx_ack", 64'(uart_rx_ack), 64'(e.ack));
          check("latency",     64'(cyc),         64'(e.cyc));
        end
      end else begin
        check("rd_err_idle", 64'(rd_err),      64'd0);
        check("ack_idle",    64'(uart_rx_ack), 64'd0);
      end
    end
  end

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [31:0] d, input logic e, input logic a, input int c);
    exp_t x;
    x.data = d; x.err = e; x.ack = a; x.cyc = c;
    sb.push_back(x);
  endtask

  // Issues rd_req in cycle n; returns during cycle n+1 with rd_req dropped.
  task automatic start_read(input logic [10:0] a, output int n);
    @(posedge clk); #1;
    rd_req  = 1'b1;
    rd_addr = a;
    n       = cyc;
    @(posedge clk); #1;
    rd_req  = 1'b0;
  endtask

  task automatic mem_read(input logic [10:0] a, input logic [31:0] d);
    int n;
    start_read(a, n);
    push(d, 1'b0, 1'b0, n + 2);
    mem_rdata = d;            // RAM output valid in cycle n+1
    @(posedge clk); #1;
    mem_rdata = JUNK;
  endtask

  task automatic simple_read(input logic [10:0] a, input logic [31:0] d, input logic e);
    int n;
    start_read(a, n);
    push(d, e, 1'b0, n + 2);
    wait_until(n + 3);
  endtask

  initial begin
    int n;
    rst           = 1'b1;
    rd_req        = 1'b0;
    rd_addr       = '0;
    mem_rdata     = JUNK;
    switch_in     = '0;
    button_in     = '0;
    uart_rx_data  = '0;
    uart_rx_valid = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_rd_valid", 64'(rd_valid),    64'd0);
    check("reset_rd_err",   64'(rd_err),      64'd0);
    check("reset_ack",      64'(uart_rx_ack), 64'd0);
    check("reset_rd_data",  64'(rd_data),     64'd0);
    check("reset_stall",    64'(stall),       64'd0);
    @(negedge clk);
    rst = 1'b0;

    // MEM read with stall timing.
    @(posedge clk); #1;
    check("stall_idle", 64'(stall), 64'd0);
    rd_req  = 1'b1;
    rd_addr = 11'h010;
    n       = cyc;
    push(32'hDEAD_BEEF, 1'b0, 1'b0, n + 2);
    #1;
    check("stall_req_cycle", 64'(stall), 64'd1);
    @(posedge clk); #1;
    rd_req    = 1'b0;
    mem_rdata = 32'hDEAD_BEEF;
    check("stall_fetch_cycle", 64'(stall), 64'd1);
    @(posedge clk); #1;
    mem_rdata = JUNK;
    check("stall_valid_cycle", 64'(stall), 64'd0);
    wait_until(n + 5);
    check("rd_data_hold", 64'(rd_data), 64'h0000_0000_DEAD_BEEF);

    mem_read(11'h3FF, 32'h0BAD_C0DE);

    // Switch and button reads.
    switch_in = 16'hA5A5;
    button_in = 5'b10010;
    repeat (3) @(posedge clk);
    simple_read(11'h402, 32'h0000_A5A5, 1'b0);
    simple_read(11'h403, 32'h0000_0012, 1'b0);

    // Write-only / unmapped reads.
    simple_read(11'h404, 32'h0, 1'b1);
    simple_read(11'h5A0, 32'h0, 1'b1);
    simple_read(11'h401, 32'h0, 1'b1);
    simple_read(11'h400, 32'h0, 1'b1);
    simple_read(11'h7FF, 32'h0, 1'b1);

    // UART: byte arrives at n+6, response at n+7.
    start_read(11'h405, n);
    push(32'h41, 1'b0, 1'b1, n + 7);
    wait_until(n + 6);
    check("stall_uart_wait", 64'(stall), 64'd1);
    uart_rx_data  = 8'h41;
    uart_rx_valid = 1'b1;
    wait_until(n + 7);
    uart_rx_valid = 1'b0;
    check("stall_uart_done", 64'(stall), 64'd0);
    wait_until(n + 9);

    // UART with byte already waiting: response at n+2.
    uart_rx_data  = 8'h7E;
    uart_rx_valid = 1'b1;
    start_read(11'h405, n);
    push(32'h7E, 1'b0, 1'b1, n + 2);
    wait_until(n + 2);
    uart_rx_valid = 1'b0;
    wait_until(n + 4);

`ifdef IO_READ_TIMEOUT_EN
    // Timeout with no byte.
    start_read(11'h405, n);
    push(32'h0, 1'b1, 1'b0, n + 2 + T);
    wait_until(n + 4 + T);
    // Byte arriving in the expiry cycle wins.
    start_read(11'h405, n);
    push(32'h3C, 1'b0, 1'b1, n + 2 + T);
    wait_until(n + 1 + T);
    uart_rx_data  = 8'h3C;
    uart_rx_valid = 1'b1;
    wait_until(n + 2 + T);
    uart_rx_valid = 1'b0;
    wait_until(n + 4 + T);
`else
    // Without timeout the wait is indefinite.
    start_read(11'h405, n);
    wait_until(n + 40);
    check("stall_long_wait", 64'(stall), 64'd1);
    uart_rx_data  = 8'h3C;
    uart_rx_valid = 1'b1;
    push(32'h3C, 1'b0, 1'b1, n + 41);
    wait_until(n + 41);
    uart_rx_valid = 1'b0;
    wait_until(n + 43);
`endif

    // Reset mid-wait aborts with no response.
    mem_read(11'h020, 32'hCAFE_F00D);
    start_read(11'h405, n);
    wait_until(n + 3);
    check("stall_before_reset", 64'(stall), 64'd1);
    rst = 1'b1;
    #1;
    check("abort_rd_valid", 64'(rd_valid),    64'd0);
    check("abort_rd_err",   64'(rd_err),      64'd0);
    check("abort_ack",      64'(uart_rx_ack), 64'd0);
    check("abort_rd_data",  64'(rd_data),     64'd0);
    check("abort_stall",    64'(stall),       64'd0);
    uart_rx_data  = 8'h55;
    uart_rx_valid = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    uart_rx_valid = 1'b0;
    mem_read(11'h011, 32'h1357_9BDF);

    // Drain the scoreboard within a bounded number of cycles.
    n = cyc;
    while (sb.size() != 0 && cyc < n + 50) begin
      @(posedge clk); #1;
    end
    check("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
